// File: rtl/operand_arbiter_2.sv
// operand_arbiter_2: two-requester round-robin arbiter with burst limit.
// It drives the 2:1 operand mux select and registers the selected beat
// into a one-entry output register that has a valid/ready handshake.
// Ports:
//   clk, rst             clock, async active-high reset
//   req0/data0 -> gnt0   requester 0 handshake (gnt = beat accepted)
//   req1/data1 -> gnt1   requester 1 handshake
//   sel                  registered mux select (0: data0, 1: data1)
//   out_valid/out_data   registered operand toward the PE array
//   out_ready            consumer accepts out_data this cycle
module operand_arbiter_2 #(
  parameter int DATA_W    = 5,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
  output logic              sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_last_owner;
  logic              w_last_next;
  logic              r_sel;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CW-1:0]     r_burst_cnt;
  logic [CW-1:0]     w_cnt_inc;
  logic [CW-1:0]     w_cnt_next;
  logic              w_slot_free;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_acc;
  logic [DATA_W-1:0] w_mux;

  // The output register can take a beat if empty or being drained now.
  assign w_slot_free = !r_out_valid | out_ready;

  assign w_gnt0 = (r_state == OWN0) & req0 & w_slot_free;
  assign w_gnt1 = (r_state == OWN1) & req1 & w_slot_free;
  assign w_acc  = w_gnt0 | w_gnt1;

  // sel always equals the owner while in an OWN state.
  assign w_mux = r_sel ? data1 : data0;

  // Saturating increment: the counter never wraps on a lone owner.
  assign w_cnt_inc  = (r_burst_cnt == MAXC) ? MAXC
                                            : r_burst_cnt + 1'b1;
  assign w_cnt_next = w_acc ? w_cnt_inc : r_burst_cnt;

  always_comb begin
    w_next      = r_state;
    w_last_next = r_last_owner;
    unique case (r_state)
      IDLE: begin
        if (req0 & req1) begin
          w_next = r_last_owner ? OWN0 : OWN1;
        end else if (req0) begin
          w_next = OWN0;
        end else if (req1) begin
          w_next = OWN1;
        end
      end
      OWN0: begin
        if (req1 & ((w_cnt_next == MAXC) | !req0)) begin
          w_next      = OWN1;
          w_last_next = 1'b0;
        end else if (!req0 & !req1) begin
          w_next      = IDLE;
          w_last_next = 1'b0;
        end
      end
      OWN1: begin
        if (req0 & ((w_cnt_next == MAXC) | !req1)) begin
          w_next      = OWN0;
          w_last_next = 1'b1;
        end else if (!req0 & !req1) begin
          w_next      = IDLE;
          w_last_next = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_next;
      r_last_owner <= w_last_next;
      // Any ownership change starts a fresh burst.
      if (w_next != r_state) begin
        r_burst_cnt <= '0;
      end else begin
        r_burst_cnt <= w_cnt_next;
      end
    end
  end

  // Select tracks the upcoming owner so the new owner can be granted
  // the very next cycle; it holds its value through IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel <= 1'b0;
    end else if (w_next == OWN0) begin
      r_sel <= 1'b0;
    end else if (w_next == OWN1) begin
      r_sel <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign sel       = r_sel;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: doc/operand_arbiter_2.md
Name: operand_arbiter_2

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 5-bit 2:1 operand mux in the CNN datapath.
- Grants one requester at a time and drives the mux select.
- Captures the granted operand into a single-entry output register with a valid/ready handshake toward the PE array.
- Burst-limited ownership stops either requester from starving the other.

Parameters:
- DATA_W, 5, operand width; matches the mux data width.
- MAX_BURST, 4, maximum consecutive accepted beats per owner while the other requester waits (>=1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 has a valid operand on data0.
- data0  in  DATA_W  requester 0 operand.
- gnt0  out  1  requester 0 beat accepted this cycle (ready).
- req1  in  1  requester 1 has a valid operand on data1.
- data1  in  DATA_W  requester 1 operand.
- gnt1  out  1  requester 1 beat accepted this cycle (ready).
- sel  out  1  mux select: 0 routes data0, 1 routes data1.
- out_valid  out  1  out_data holds a beat.
- out_data  out  DATA_W  registered operand.
- out_ready  in  1  consumer accepts out_data this cycle.

Behaviour:
- Reset values (rst high, asynchronous):
  - state=IDLE, sel=0, out_valid=0, out_data=0, burst_cnt=0.
  - last_owner=1, so req0 wins the first tie.
  - gnt0=gnt1=0 while rst is high.
  - Reset mid-burst discards any beat held in the output register.
- slot_free = !out_valid | out_ready.
- Grants (combinational):
  - gnt0 = (state==OWN0) & req0 & slot_free.
  - gnt1 = (state==OWN1) & req1 & slot_free.
  - Never both high. Never high in IDLE.
- Accept: acc = gnt0|gnt1.
  - On acc: out_data<=data of owner, out_valid<=1.
  - Else if out_ready: out_valid<=0.
  - Else: hold.
  - out_data is stable while out_valid & !out_ready.
- sel is registered. It equals the owner in OWN0/OWN1 and holds its last value in IDLE.
- Latency:
  - req to first grant: 1 cycle, for the IDLE to OWN transition.
  - Grant to out_valid: 1 cycle.
  - Sustained throughput: 1 beat/cycle with out_ready=1.
- burst_cnt width is clog2(MAX_BURST+1).
  - cnt_next = acc ? min(cnt+1, MAX_BURST) : cnt, so it saturates and never wraps.
  - cnt clears to 0 on any state change.
- FSM, with i = owner and j = the other requester:
  - IDLE, req0&req1: go to OWN(!last_owner).
  - IDLE, only reqk: go to OWNk.
  - IDLE, no request: stay.
  - OWNi, reqj & (cnt_next==MAX_BURST | !reqi): go to OWNj, last_owner<=i.
  - OWNi, !reqi & !reqj: go to IDLE, last_owner<=i.
  - OWNi, otherwise: stay.
  - No bubble between owners when switching OWN to OWN. The new owner can be granted the cycle after the edge on which the old owner's last beat was accepted.
- A lone owner keeps ownership indefinitely; the counter saturates.
- If a competitor arrives while cnt==MAX_BURST, the switch happens on the next edge.
- Backpressure (out_ready=0 with out_valid=1) deasserts the grant. burst_cnt does not advance and the state holds unless the owner drops req.
- Requesters must hold req/data stable until granted. Dropping req before a grant is legal and yields no beat.

Test Plan:
- Reset: assert rst mid-operation with out_valid=1 -> on the same cycle out_valid=0, out_data=0, sel=0, gnt0=gnt1=0. After release with req0=req1=1, OWN0 is entered first.
- Single requester: req0=1, data0=1,2,3...10, out_ready=1 -> gnt0 first high 1 cycle after req0, out_data=1..10 on consecutive cycles, sel stays 0, gnt1 never high.
- Contention: req0=req1=1 continuously, MAX_BURST=4, out_ready=1 -> accepted-owner sequence 0,0,0,0,1,1,1,1,0,... with no idle cycle; out_valid stays 1 and sel toggles every 4 beats.
- Backpressure: one beat 5'h1A held, then out_ready=0 for 3 cycles -> out_data=5'h1A and out_valid=1 held, gnt0=0, burst_cnt unchanged; the next beat is granted on the cycle out_ready returns to 1.
- Early release: OWN0 after 2 beats, req0 drops while req1=1 -> OWN1 on the next edge, gnt1 high the following cycle, burst_cnt restarts at 0.
- Idle return: both requests drop during OWN1 -> IDLE, sel stays 1. A later req0&req1 together -> OWN0, per last_owner=1.
